// File: rtl/tate_host_seq_pkg.sv
// tate_host_seq_pkg
// Shared definitions for the pairing host sequencer:
//   - state_t      : sequencer FSM encoding (IDLE, LOAD, RUN, RD, OUT)
//   - DEF_*        : default operand/result placement in the operand RAM
//   - CONST_ADDR   : RAM words reserved for microcode constants; the
//                    IN and OUT windows must be placed clear of these
package tate_host_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RD,
    S_OUT
  } state_t;

  localparam int DEF_IN_BASE  = 32;
  localparam int DEF_N_IN     = 4;
  localparam int DEF_OUT_BASE = 40;
  localparam int DEF_N_OUT    = 6;

  // Constant words preloaded for the microcode (zero, one, curve b, etc.).
  localparam int N_CONST = 4;
  localparam int unsigned CONST_ADDR [N_CONST] = '{0, 1, 2, 3};

endpackage

// File: rtl/tate_host_seq.sv
// tate_host_seq
// Host-side sequencer in front of the pairing microcode controller. It
// writes N_IN operand words into the shared operand RAM, releases the
// controller from reset, waits for its done level (or a timeout), then
// reads N_OUT result words back out through a valid/ready port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 begin a job (only looked at while idle)
//   busy, job_done, err   status: not idle / last result accepted / timeout
//   in_data/valid/ready   operand stream into the RAM
//   out_data/valid/ready  result stream out of the RAM (out_data registered)
//   ram_sel               1 = host owns the RAM port, 0 = controller owns it
//   ram_addr/wdata/we     host side of the RAM port
//   ram_rdata             RAM read data for the presented address
//   core_reset            registered synchronous reset to the controller
//   core_done             controller done level
module tate_host_seq
  import tate_host_seq_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 194,
  parameter int IN_BASE  = DEF_IN_BASE,
  parameter int N_IN     = DEF_N_IN,
  parameter int OUT_BASE = DEF_OUT_BASE,
  parameter int N_OUT    = DEF_N_OUT,
  parameter int TIMEOUT  = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              job_done,
  output logic              err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              core_reset,
  input  logic              core_done
);

  localparam int MAXN  = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int IDX_W = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] run_cnt, cnt_nxt;
  logic             err_nxt;

  assign busy      = (state != S_IDLE);
  assign ram_wdata = in_data;

  // Next-state and combinational outputs. The run counter is held at zero
  // outside RUN so every job starts its timeout window fresh. In RUN,
  // core_done is checked before the timeout so a done arriving on the
  // last allowed cycle still drains normally with err left clear.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = '0;
    err_nxt   = err;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    out_valid = 1'b0;
    job_done  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        ram_we   = in_valid;
        ram_addr = ADDR_W'(IN_BASE) + ADDR_W'(idx);
        if (in_valid) begin
          if (idx == LAST_IN) begin
            state_nxt = S_RUN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      S_RUN: begin
        cnt_nxt = run_cnt + 1'b1;
        if (core_done) begin
          state_nxt = S_RD;
        end else if (run_cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end

      S_RD: begin
        ram_addr  = ADDR_W'(OUT_BASE) + ADDR_W'(idx);
        state_nxt = S_OUT;
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST_OUT) begin
            job_done  = 1'b1;
            idx_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_RD;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers. core_reset and ram_sel are registered
  // from the next state so they change exactly on RUN entry/exit without
  // combinational glitches reaching the controller. out_data loads only
  // at the end of RD, so it holds steady for the whole OUT stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      run_cnt    <= '0;
      err        <= 1'b0;
      core_reset <= 1'b1;
      ram_sel    <= 1'b1;
      out_data   <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      run_cnt    <= cnt_nxt;
      err        <= err_nxt;
      core_reset <= (state_nxt != S_RUN);
      ram_sel    <= (state_nxt != S_RUN);
      if (state == S_RD) begin
        out_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tate_host_seq.sv
// tb_tate_host_seq
// Scoreboard bench for tate_host_seq. Jobs push expected RAM writes and
// expected result words into queues; a negedge monitor pops and compares
// whenever the DUT writes the RAM or hands over a result word. A small
// controller model computes result word k as operand[k%4] + (k+1)*165
// and writes it into RAM[40+k] while it owns the port.
module tb_tate_host_seq;

  localparam int TB_TO = 128;
  localparam int NW    = 6;

  logic         clk, reset, start, busy, job_done, err;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         ram_sel, ram_we, core_reset, core_done;
  logic [193:0] in_data, out_data, ram_wdata, ram_rdata;
  logic [5:0]   ram_addr;

  typedef struct packed {
    logic [193:0] data;
    logic         last;
  } exp_t;

  typedef struct packed {
    logic [5:0]   addr;
    logic [193:0] data;
  } wr_t;

  exp_t         exp_q[$];
  wr_t          wr_q[$];
  exp_t         mon_e;
  wr_t          mon_w;
  logic [193:0] mem [64];
  logic [193:0] ops [4];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           ctrl_cnt = 0;

  tate_host_seq #(.TIMEOUT(TB_TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .job_done   (job_done),
    .err        (err),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ram_sel    (ram_sel),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .core_reset (core_reset),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM plus controller model: host writes while ram_sel=1, controller
  // writes its results in its first NW cycles out of reset.
  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_sel) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ctrl_cnt <= 0;
    end else begin
      if (ctrl_cnt < NW)
        mem[40 + ctrl_cnt] <= mem[32 + ctrl_cnt % 4] + 194'((ctrl_cnt + 1) * 165);
      ctrl_cnt <= ctrl_cnt + 1;
    end
  end

  function automatic logic [193:0] res(input int k);
    return ops[k % 4] + 194'((k + 1) * 165);
  endfunction

  task automatic checkOutput(input string name, input logic [193:0] act, input logic [193:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    $display("[TB] reset values check: %s", tag);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_job_done", job_done, 1'b0);
    checkBit("rst_err", err, 1'b0);
    checkBit("rst_in_ready", in_ready, 1'b0);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 194'd0);
    checkBit("rst_ram_sel", ram_sel, 1'b1);
    checkBit("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", 194'(ram_addr), 194'd0);
    checkBit("rst_core_reset", core_reset, 1'b1);
  endtask

  // Monitor: compares every RAM write and every accepted result word
  // against the queues; result words must also hold while stalled.
  always @(negedge clk) begin
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr %0d expected no write", ram_addr);
      end else begin
        mon_w = wr_q.pop_front();
        checkOutput("write_addr", 194'(ram_addr), 194'(mon_w.addr));
        checkOutput("write_data", ram_wdata, mon_w.data);
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got %0h expected no result", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result_data", out_data, mon_e.data);
        checkBit("job_done_on_last", job_done, mon_e.last);
      end
    end else begin
      if (job_done) begin
        total++;
        bad++;
        $display("[TB] FAIL job_done_stray: got 1 expected 0");
      end
      if (out_valid && exp_q.size() > 0)
        checkOutput("out_data_stalled", out_data, exp_q[0].data);
    end
  end

  task automatic setOps(input logic [193:0] a, b, c, d);
    ops[0] = a;
    ops[1] = b;
    ops[2] = c;
    ops[3] = d;
  endtask

  // One job. done_dly: RUN cycle (1-based) in which core_done is high,
  // 0 = never. stall: out_ready low cycles per word. gaps: idle cycle
  // before each operand beat. abort: 1 = reset in RUN, 2 = reset in OUT.
  // pokes: start/core_done during LOAD and start during RUN.
  task automatic applyStimulus(input int done_dly, input int stall, input bit gaps,
                               input int abort, input bit pokes);
    int   ne;
    int   n;
    int   t_first;
    int   t_last;
    exp_t e;
    wr_t  w;
    ne = 0;
    t_first = 0;
    t_last = 0;
    if (abort == 0 && done_dly != 0) begin
      for (int k = 0; k < NW; k++) begin
        e.data = res(k);
        e.last = (k == NW - 1);
        exp_q.push_back(e);
      end
    end
    in_valid = 1'b1;
    in_data  = '1;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkBit("in_ready_after_start", in_ready, 1'b1);
    checkBit("busy_in_load", busy, 1'b1);
    checkBit("err_cleared_by_start", err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = ~ops[i];
        tick();
      end
      if (pokes && i == 1) begin
        start     = 1'b1;
        core_done = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      w.addr = 6'(32 + i);
      w.data = ops[i];
      wr_q.push_back(w);
      tick();
      start     = 1'b0;
      core_done = 1'b0;
    end
    in_valid = 1'b0;
    checkBit("core_reset_low_in_run", core_reset, 1'b0);
    checkBit("ram_sel_low_in_run", ram_sel, 1'b0);
    if (abort == 1) begin
      repeat (3) tick();
      reset = 1'b1;
      #1;
      checkResetValues("reset_in_run");
      tick();
      reset = 1'b0;
      return;
    end
    if (pokes) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      ne = 1;
      checkBit("busy_after_start_in_run", busy, 1'b1);
      checkBit("ram_sel_after_start_in_run", ram_sel, 1'b0);
    end
    if (done_dly == 0) begin
      n = 0;
      while (busy && n < TB_TO + 20) begin
        tick();
        ne++;
        n++;
      end
      checkOutput("timeout_run_cycles", 194'(ne), 194'(TB_TO));
      checkBit("err_after_timeout", err, 1'b1);
      checkBit("core_reset_after_timeout", core_reset, 1'b1);
      checkBit("ram_sel_after_timeout", ram_sel, 1'b1);
      checkBit("idle_after_timeout", busy, 1'b0);
      return;
    end
    while (ne < done_dly - 1) begin
      tick();
      ne++;
    end
    checkBit("ram_sel_before_done", ram_sel, 1'b0);
    out_ready = (stall == 0 && abort == 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkBit("core_reset_in_rd", core_reset, 1'b1);
    checkBit("ram_sel_in_rd", ram_sel, 1'b1);
    checkBit("out_valid_low_in_rd", out_valid, 1'b0);
    checkBit("err_low_after_done", err, 1'b0);
    tick();
    checkBit("out_valid_two_after_done", out_valid, 1'b1);
    if (abort == 2) begin
      tick();
      reset = 1'b1;
      #1;
      checkResetValues("reset_in_out");
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      return;
    end
    for (int wd = 0; wd < NW; wd++) begin
      n = 0;
      while (!out_valid && n < 8) begin
        tick();
        n++;
      end
      checkBit("result_valid_in_time", out_valid, 1'b1);
      if (stall > 0) begin
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end else begin
        if (wd == 0) t_first = cyc;
        if (wd == NW - 1) t_last = cyc;
        tick();
      end
    end
    if (stall == 0)
      checkOutput("drain_span", 194'(t_last - t_first), 194'(2 * (NW - 1)));
    checkBit("idle_after_job", busy, 1'b0);
    checkBit("err_after_job", err, 1'b0);
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    core_done = 1'b0;
    tick();
    checkResetValues("power_on");
    reset = 1'b0;
    tick();

    $display("[TB] nominal job");
    setOps(194'd1, 194'd2, 194'd3, 194'd4);
    applyStimulus(100, 0, 1'b0, 0, 1'b0);

    $display("[TB] back-pressure job");
    setOps(194'h3 << 190, 194'h1234_5678_9abc, 194'hfff << 100, 194'd77);
    applyStimulus(20, 5, 1'b1, 0, 1'b0);

    $display("[TB] timeout job");
    setOps(194'd9, 194'd8, 194'd7, 194'd6);
    applyStimulus(0, 0, 1'b0, 0, 1'b0);

    $display("[TB] job after timeout");
    setOps(194'd100, 194'd200, 194'd300, 194'd400);
    applyStimulus(30, 0, 1'b0, 0, 1'b0);

    $display("[TB] ignored start and core_done");
    setOps(194'h5a, 194'ha5 << 150, 194'h11, 194'h22);
    applyStimulus(25, 0, 1'b0, 0, 1'b1);

    $display("[TB] reset in RUN then fresh job");
    setOps(194'd13, 194'd14, 194'd15, 194'd16);
    applyStimulus(40, 0, 1'b0, 1, 1'b0);
    setOps(194'd21, 194'd22, 194'd23, 194'd24);
    applyStimulus(40, 0, 1'b0, 0, 1'b0);

    $display("[TB] reset in OUT then fresh job");
    setOps(194'd31, 194'd32, 194'd33, 194'd34);
    applyStimulus(15, 0, 1'b0, 2, 1'b0);
    setOps(194'h7 << 180, 194'd42, 194'd43, 194'd44);
    applyStimulus(15, 2, 1'b0, 0, 1'b0);

    $display("[TB] core_done on last timeout cycle");
    setOps(194'd51, 194'd52, 194'd53, 194'd54);
    applyStimulus(TB_TO, 0, 1'b0, 0, 1'b0);

    repeat (3) tick();
    checkOutput("results_left", 194'(exp_q.size()), 194'd0);
    checkOutput("writes_left", 194'(wr_q.size()), 194'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
